// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RISC-V pipeline: operand
// forwarding, load-use stalls, sequenced redirect flushes and event counters.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             resultsrc_e,
    input  logic             pcsrc_e,
    input  logic [4:0]       rd_m,
    input  logic             regwrite_m,
    input  logic [4:0]       rd_w,
    input  logic             regwrite_w,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, FLUSH} state_t;

    // Extra FLUSH cycles after the redirect cycle itself, minus one.
    localparam logic [1:0] FCNT_INIT = 2'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    state_t            state_reg, state_next;
    logic [1:0]        fcnt_reg, fcnt_next;
    logic              lu;
    logic              accept;
    logic [CNT_W-1:0]  stall_count_reg, flush_count_reg;
    logic [1:0][4:0]   rs_e;
    logic [1:0][1:0]   fwd_sel;

    // Forwarding depends only on pipeline tags and rst, never on state.
    assign rs_e = {rs2_e, rs1_e};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] =
                rst ? 2'b00 :
                (regwrite_m && (rd_m != 5'd0) && (rd_m == rs_e[gi])) ? 2'b10 :
                (regwrite_w && (rd_w != 5'd0) && (rd_w == rs_e[gi])) ? 2'b01 :
                2'b00;
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    assign lu = resultsrc_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        state_next = state_reg;
        fcnt_next  = fcnt_reg;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        accept     = 1'b0;
        if (!rst) begin
            case (state_reg)
                RUN: begin
                    if (pcsrc_e) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                        accept  = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_next = FLUSH;
                            fcnt_next  = FCNT_INIT;
                        end
                    end else if (lu) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                FLUSH: begin
                    // Wrong-path redirects and load-uses are squashed here.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    if (fcnt_reg == 2'd0) begin
                        state_next = RUN;
                    end else begin
                        fcnt_next = fcnt_reg - 2'd1;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            fcnt_reg        <= 2'd0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
            if (stall_d && (stall_count_reg != {CNT_W{1'b1}})) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
            if (accept && (flush_count_reg != {CNT_W{1'b1}})) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end

    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized plus directed bench for hazard_ctrl; three instances with different
// FLUSH_CYCLES/CNT_W share stimulus and are checked against a behavioural model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       resultsrc_e, pcsrc_e, regwrite_m, regwrite_w;

    logic       sf [3];
    logic       sd [3];
    logic       fd [3];
    logic       fe [3];
    logic [1:0] fa [3];
    logic [1:0] fb [3];
    logic [31:0] sc0, fc0;
    logic [3:0]  sc1, fc1;
    logic [7:0]  sc2, fc2;
    logic [63:0] scnt [3];
    logic [63:0] fcnt [3];

    localparam int FC [3] = '{1, 3, 4};
    localparam int CW [3] = '{32, 4, 8};

    int errors = 0;
    int checks = 0;

    // Model state: flush cycles still owed after the redirect cycle, and counts.
    int     rem      [3];
    longint exp_scnt [3];
    longint exp_fcnt [3];

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .resultsrc_e(resultsrc_e), .pcsrc_e(pcsrc_e), .rd_m(rd_m),
        .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .stall_f(sf[0]), .stall_d(sd[0]), .flush_d(fd[0]), .flush_e(fe[0]),
        .fwd_a(fa[0]), .fwd_b(fb[0]), .stall_count(sc0), .flush_count(fc0));

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .resultsrc_e(resultsrc_e), .pcsrc_e(pcsrc_e), .rd_m(rd_m),
        .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .stall_f(sf[1]), .stall_d(sd[1]), .flush_d(fd[1]), .flush_e(fe[1]),
        .fwd_a(fa[1]), .fwd_b(fb[1]), .stall_count(sc1), .flush_count(fc1));

    hazard_ctrl #(.FLUSH_CYCLES(4), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .resultsrc_e(resultsrc_e), .pcsrc_e(pcsrc_e), .rd_m(rd_m),
        .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .stall_f(sf[2]), .stall_d(sd[2]), .flush_d(fd[2]), .flush_e(fe[2]),
        .fwd_a(fa[2]), .fwd_b(fb[2]), .stall_count(sc2), .flush_count(fc2));

    assign scnt[0] = {32'd0, sc0};
    assign fcnt[0] = {32'd0, fc0};
    assign scnt[1] = {60'd0, sc1};
    assign fcnt[1] = {60'd0, fc1};
    assign scnt[2] = {56'd0, sc2};
    assign fcnt[2] = {56'd0, fc2};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (rst) return 2'b00;
        if (regwrite_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (regwrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        rst = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        resultsrc_e = 0; pcsrc_e = 0; regwrite_m = 0; regwrite_w = 0;
    endtask

    // Inputs are already driven (after a falling edge); check, then advance one clock.
    task automatic do_cycle(input string what);
        logic lu;
        logic e_sf, e_sd, e_fd, e_fe, acc;
        longint cmax;
        lu = resultsrc_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        #1;
        for (int k = 0; k < 3; k++) begin
            e_sf = 0; e_sd = 0; e_fd = 0; e_fe = 0; acc = 0;
            if (!rst) begin
                if (rem[k] > 0) begin
                    e_fd = 1; e_fe = 1;
                end else if (pcsrc_e) begin
                    e_fd = 1; e_fe = 1; acc = 1;
                end else if (lu) begin
                    e_sf = 1; e_sd = 1; e_fe = 1;
                end
            end
            check($sformatf("%s d%0d stall_f", what, k), 64'(sf[k]), 64'(e_sf));
            check($sformatf("%s d%0d stall_d", what, k), 64'(sd[k]), 64'(e_sd));
            check($sformatf("%s d%0d flush_d", what, k), 64'(fd[k]), 64'(e_fd));
            check($sformatf("%s d%0d flush_e", what, k), 64'(fe[k]), 64'(e_fe));
            check($sformatf("%s d%0d fwd_a", what, k), 64'(fa[k]), 64'(fwd_model(rs1_e)));
            check($sformatf("%s d%0d fwd_b", what, k), 64'(fb[k]), 64'(fwd_model(rs2_e)));
            cmax = (CW[k] >= 63) ? 64'hFFFF_FFFF : ((64'd1 << CW[k]) - 1);
            if (rst) begin
                rem[k] = 0; exp_scnt[k] = 0; exp_fcnt[k] = 0;
            end else begin
                if (rem[k] > 0) rem[k]--;
                else if (acc) rem[k] = FC[k] - 1;
                if (e_sd && exp_scnt[k] < cmax) exp_scnt[k]++;
                if (acc && exp_fcnt[k] < cmax) exp_fcnt[k]++;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s d%0d stall_count", what, k), scnt[k], 64'(exp_scnt[k]));
            check($sformatf("%s d%0d flush_count", what, k), fcnt[k], 64'(exp_fcnt[k]));
        end
        $display("cycle %-10s rst=%0d pcsrc=%0d lu=%0d sc=%0d/%0d/%0d fc=%0d/%0d/%0d",
                 what, rst, pcsrc_e, lu, sc0, sc1, sc2, fc0, fc1, fc2);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0; exp_scnt[k] = 0; exp_fcnt[k] = 0;
        end
        idle();
        rst = 1;
        @(negedge clk);
        do_cycle("reset");
        do_cycle("reset");
        idle();

        // Forwarding priority and x0 suppression
        rs1_e = 5; rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
        do_cycle("fwd_mem");
        regwrite_m = 0;
        do_cycle("fwd_wb");
        rd_m = 0; rd_w = 0; rs2_e = 0; regwrite_m = 1;
        do_cycle("fwd_x0");
        idle();

        // Load-use for one cycle then bubble; rd_e=0 never stalls
        resultsrc_e = 1; rd_e = 7; rs2_d = 7;
        do_cycle("lu");
        idle();
        do_cycle("bubble");
        resultsrc_e = 1; rd_e = 0; rs2_d = 0;
        do_cycle("lu_x0");
        idle();

        // Redirect pulses, then held redirect followed by load-use
        pcsrc_e = 1; do_cycle("redir");
        pcsrc_e = 0; repeat (3) do_cycle("idle");
        pcsrc_e = 1; do_cycle("redir");
        pcsrc_e = 0; repeat (4) do_cycle("idle");
        pcsrc_e = 1; repeat (3) do_cycle("redir_hold");
        pcsrc_e = 0; resultsrc_e = 1; rd_e = 3; rs1_d = 3;
        do_cycle("lu_after");
        idle(); repeat (4) do_cycle("idle");

        // Redirect and load-use together
        pcsrc_e = 1; resultsrc_e = 1; rd_e = 9; rs1_d = 9;
        do_cycle("both");
        idle(); repeat (4) do_cycle("idle");

        // Reset on the second flush cycle
        pcsrc_e = 1; do_cycle("redir");
        idle(); rst = 1; do_cycle("rst_mid");
        idle(); repeat (2) do_cycle("post_rst");

        // Saturation of the narrow counters
        resultsrc_e = 1; rd_e = 4; rs2_d = 4;
        repeat (20) do_cycle("lu_hold");
        idle(); do_cycle("idle");
        pcsrc_e = 1; pcsrc_e = 1;
        repeat (20) begin
            pcsrc_e = 1; do_cycle("redir_sat");
            pcsrc_e = 0; repeat (4) do_cycle("idle");
        end

        // Random traffic over a small register range so hazards are common
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(99) < 3);
            pcsrc_e     = ($urandom_range(99) < 15);
            resultsrc_e = ($urandom_range(99) < 40);
            regwrite_m  = $urandom_range(1);
            regwrite_w  = $urandom_range(1);
            rs1_d = 5'($urandom_range(3)); rs2_d = 5'($urandom_range(3));
            rs1_e = 5'($urandom_range(3)); rs2_e = 5'($urandom_range(3));
            rd_e  = 5'($urandom_range(3)); rd_m  = 5'($urandom_range(3));
            rd_w  = 5'($urandom_range(3));
            do_cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RISC-V core.
- Consumes the stage-tagged register and control signals produced by the pipeline registers and drives control back into them: fetch/decode stalls, decode/execute flushes, and EX-stage operand forwarding selects.
- Adds a sequenced redirect-flush FSM and saturating stall/flush event counters for performance visibility.

Parameters:
- FLUSH_CYCLES, 1, total cycles flush_d/flush_e stay asserted per accepted redirect; legal range 1..4.
- CNT_W, 32, width of stall_count and flush_count.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- rs1_d  in  5  rs1 of instruction in decode
- rs2_d  in  5  rs2 of instruction in decode
- rs1_e  in  5  rs1 of instruction in execute
- rs2_e  in  5  rs2 of instruction in execute
- rd_e  in  5  rd of instruction in execute
- resultsrc_e  in  1  execute instruction is a load (result from data memory)
- pcsrc_e  in  1  taken branch/jump resolved in execute
- rd_m  in  5  rd in memory stage
- regwrite_m  in  1  memory-stage instruction writes register
- rd_w  in  5  rd in writeback stage
- regwrite_w  in  1  writeback-stage instruction writes register
- stall_f  out  1  hold PC
- stall_d  out  1  hold IF/ID register
- flush_d  out  1  clear IF/ID register to bubble
- flush_e  out  1  clear ID/EX register to bubble
- fwd_a  out  2  EX operand A select: 00 register file, 01 writeback result, 10 memory ALU result
- fwd_b  out  2  same encoding for operand B
- stall_count  out  CNT_W  cycles with stall_d=1
- flush_count  out  CNT_W  accepted redirects

Behaviour:
- Forwarding (combinational):
  - fwd_a=10 if regwrite_m, rd_m!=0 and rd_m==rs1_e.
  - Else fwd_a=01 if regwrite_w, rd_w!=0 and rd_w==rs1_e.
  - Else 00.
  - fwd_b is identical using rs2_e.
  - Memory stage has priority over writeback.
  - x0 is never forwarded.
- Load-use detection (combinational): lu = resultsrc_e and rd_e!=0 and (rd_e==rs1_d or rd_e==rs2_d).
- FSM states: RUN, FLUSH. A down-counter fcnt (2 bits) is used in FLUSH.
- RUN, pcsrc_e=1:
  - Redirect is accepted: flush_d=flush_e=1 in the same cycle, stall_f=stall_d=0, flush_count increments.
  - If FLUSH_CYCLES>1: next state FLUSH with fcnt=FLUSH_CYCLES-2. Otherwise stay in RUN.
- RUN, pcsrc_e=0 and lu=1:
  - stall_f=stall_d=flush_e=1, flush_d=0.
  - Lasts exactly while lu holds (one cycle for a single load, because the bubble clears resultsrc_e).
- RUN, otherwise: all stall/flush outputs 0.
- FLUSH:
  - flush_d=flush_e=1, stall_f=stall_d=0.
  - pcsrc_e and lu are ignored (the squashed path is not counted).
  - If fcnt==0, next state RUN; else fcnt decrements.
- Priority: an accepted redirect overrides load-use. Both asserted together means flush, not stall, and stall_count does not increment.
- Counters:
  - stall_count increments by 1 on every clock edge where stall_d=1.
  - flush_count increments by 1 on every accepted redirect.
  - Both saturate at all-ones and never wrap.
- Reset:
  - While rst=1, stall_f, stall_d, flush_d, flush_e are forced to 0 and fwd_a, fwd_b to 00.
  - At the clock edge with rst=1: state=RUN, fcnt=0, both counters=0.
  - Reset asserted mid-FLUSH aborts the sequence. The first cycle after reset deassertion is RUN.
- No combinational path from any counter or state to fwd_a/fwd_b.

Test Plan:
- Forwarding priority: rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> fwd_a=10. Drop regwrite_m -> fwd_a=01. Set rd_m=rd_w=rs2_e=0 with both writes enabled -> fwd_b=00.
- Load-use: resultsrc_e=1, rd_e=7, rs2_d=7 for one cycle, then bubble -> exactly one cycle of stall_f=stall_d=flush_e=1, stall_count=1. With rd_e=0 -> no stall.
- Redirect, FLUSH_CYCLES=1: pcsrc_e pulse -> flush_d=flush_e=1 for 1 cycle, flush_count=1. Two pulses 3 cycles apart -> flush_count=2.
- Redirect, FLUSH_CYCLES=3: pcsrc_e held high 3 cycles -> flush for 3 cycles, flush_count=1 (later pulses ignored in FLUSH). At cycle 4 lu=1 -> stall resumes.
- Simultaneous pcsrc_e=1 and lu=1 in RUN -> flush_d=flush_e=1, stall_f=stall_d=0, stall_count unchanged, flush_count+1.
- Reset mid-FLUSH (FLUSH_CYCLES=4, rst at second flush cycle) -> all outputs 0 that cycle, counters 0, next cycle RUN with no flush.
- Saturation, CNT_W=4: hold lu=1 for 20 cycles -> stall_count reaches 15 and stays at 15.
